reg_status_table: RTL and testbench

- Parametrised register result-status table for the Tomasulo core, replacing the fixed two-station, four-register table.
- Holds, per architectural register, the value and the producer tag Qi: 0 = value valid, k = waiting on reservation station k.
- Dispatch allocates tags; the CDB broadcast retires tags and writes values.
- Two operand read ports with CDB bypass feed the reservation stations; per-station done pulses release stations after write-back.

---
 rtl/tomasulo_pkg.sv | 12 +
 rtl/reg_status_table_if.sv | 37 +++
 rtl/rst_read_port.sv | 32 +++
 rtl/reg_status_table.sv | 76 +++++++
 tb/tb_reg_status_table.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/tomasulo_pkg.sv
// tomasulo_pkg: shared tag/data constants and helpers for the Tomasulo core.
package tomasulo_pkg;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_TAG_W  = 3;
    localparam logic [DEF_TAG_W-1:0]  TAG_FREE = '0;
    localparam logic [DEF_TAG_W-1:0]  Q_NONE   = TAG_FREE;
    localparam logic [DEF_DATA_W-1:0] V_NONE   = '0;

    function automatic logic tag_ok(input int tag, input int num_rs);
        return tag != 0 && tag <= num_rs;
    endfunction
endpackage

// File: rtl/reg_status_table_if.sv
// reg_status_table_if: dispatch, CDB and operand-read signals of the register status table.
interface reg_status_table_if
    import tomasulo_pkg::*;
#(
    parameter int NUM_REGS = 4,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_RS   = 4,
    parameter int TAG_W    = DEF_TAG_W,
    parameter int RA_W     = 2,
    parameter int CNT_W    = $clog2(NUM_REGS + 1)
);
    logic              flush;
    logic              disp_valid;
    logic [RA_W-1:0]   disp_rd;
    logic [TAG_W-1:0]  disp_tag;
    logic              disp_err;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic [RA_W-1:0]   rda_addr;
    logic [RA_W-1:0]   rdb_addr;
    logic [TAG_W-1:0]  rda_tag;
    logic [TAG_W-1:0]  rdb_tag;
    logic [DATA_W-1:0] rda_data;
    logic [DATA_W-1:0] rdb_data;
    logic [NUM_RS-1:0] cdb_done;
    logic [CNT_W-1:0]  pending_cnt;

    modport master (
        output flush, disp_valid, disp_rd, disp_tag, cdb_valid, cdb_tag, cdb_data, rda_addr, rdb_addr,
        input  disp_err, rda_tag, rdb_tag, rda_data, rdb_data, cdb_done, pending_cnt
    );
    modport slave (
        input  flush, disp_valid, disp_rd, disp_tag, cdb_valid, cdb_tag, cdb_data, rda_addr, rdb_addr,
        output disp_err, rda_tag, rdb_tag, rda_data, rdb_data, cdb_done, pending_cnt
    );
endinterface

// File: rtl/rst_read_port.sv
// rst_read_port: operand read of the status table with same-cycle CDB bypass.
module rst_read_port
    import tomasulo_pkg::*;
#(
    parameter int NUM_REGS = 4,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int TAG_W    = DEF_TAG_W,
    parameter int RA_W     = 2
) (
    input  logic [NUM_REGS-1:0][TAG_W-1:0]  tags_i,
    input  logic [NUM_REGS-1:0][DATA_W-1:0] data_i,
    input  logic [RA_W-1:0]                 addr_i,
    input  logic                            cdb_valid_i,
    input  logic [TAG_W-1:0]                cdb_tag_i,
    input  logic [DATA_W-1:0]               cdb_data_i,
    output logic [TAG_W-1:0]                tag_o,
    output logic [DATA_W-1:0]               data_o
);
    logic              in_range;
    logic [TAG_W-1:0]  raw_tag;
    logic [DATA_W-1:0] raw_data;
    logic              bypass;

    always_comb begin
        in_range = 32'(addr_i) < NUM_REGS;
        raw_tag  = in_range ? tags_i[addr_i] : TAG_W'(Q_NONE);
        raw_data = in_range ? data_i[addr_i] : DATA_W'(V_NONE);
        bypass   = raw_tag != '0 && cdb_valid_i && cdb_tag_i == raw_tag;
        tag_o    = bypass ? TAG_W'(Q_NONE) : raw_tag;
        data_o   = bypass ? cdb_data_i : raw_data;
    end
endmodule

// File: rtl/reg_status_table.sv
// reg_status_table: per-register value and producer tag (Qi) for Tomasulo dispatch and CDB write-back.
module reg_status_table
    import tomasulo_pkg::*;
#(
    parameter int NUM_REGS = 4,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_RS   = 4,
    parameter int TAG_W    = DEF_TAG_W,
    parameter int RA_W     = 2,
    parameter logic [NUM_REGS*DATA_W-1:0] INIT_DATA = {16'd5, 16'd3, 16'd4, 16'd2}
) (
    input logic Clock,
    input logic Reset,
    reg_status_table_if.slave bus
);
    localparam int CNT_W = $clog2(NUM_REGS + 1);

    logic [NUM_REGS-1:0][TAG_W-1:0]  tag_q, tag_d;
    logic [NUM_REGS-1:0][DATA_W-1:0] data_q, data_d;
    logic [NUM_RS-1:0]               done_q, done_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic                            err_q, err_d;
    logic                            cdb_ok, disp_ok, hit;

    always_comb begin
        cdb_ok  = bus.cdb_valid && tag_ok(32'(bus.cdb_tag), NUM_RS);
        disp_ok = bus.disp_valid && tag_ok(32'(bus.disp_tag), NUM_RS) && 32'(bus.disp_rd) < NUM_REGS;
        err_d   = bus.disp_valid && !disp_ok && !bus.flush;
        done_d  = cdb_ok ? NUM_RS'(1) << (bus.cdb_tag - TAG_W'(1)) : '0;
        cnt_d   = '0;
        hit     = 1'b0;
        tag_d   = tag_q;
        data_d  = data_q;
        // flush beats a same-cycle dispatch, which beats the CDB clearing the tag
        for (int i = 0; i < NUM_REGS; i++) begin
            hit       = cdb_ok && tag_q[i] == bus.cdb_tag;
            data_d[i] = hit ? bus.cdb_data : data_q[i];
            tag_d[i]  = bus.flush ? '0 :
                        (disp_ok && 32'(bus.disp_rd) == i) ? bus.disp_tag :
                        hit ? '0 : tag_q[i];
            cnt_d     = cnt_d + CNT_W'(tag_d[i] != '0);
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            tag_q  <= '0;
            data_q <= INIT_DATA;
            done_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            tag_q  <= tag_d;
            data_q <= data_d;
            done_q <= done_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign bus.disp_err    = err_q;
    assign bus.cdb_done    = done_q;
    assign bus.pending_cnt = cnt_q;

    rst_read_port #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .TAG_W(TAG_W), .RA_W(RA_W)) u_rda (
        .tags_i(tag_q), .data_i(data_q), .addr_i(bus.rda_addr),
        .cdb_valid_i(cdb_ok), .cdb_tag_i(bus.cdb_tag), .cdb_data_i(bus.cdb_data),
        .tag_o(bus.rda_tag), .data_o(bus.rda_data)
    );

    rst_read_port #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .TAG_W(TAG_W), .RA_W(RA_W)) u_rdb (
        .tags_i(tag_q), .data_i(data_q), .addr_i(bus.rdb_addr),
        .cdb_valid_i(cdb_ok), .cdb_tag_i(bus.cdb_tag), .cdb_data_i(bus.cdb_data),
        .tag_o(bus.rdb_tag), .data_o(bus.rdb_data)
    );
endmodule

// File: tb/tb_reg_status_table.sv
// tb_reg_status_table: directed scenarios with hand-computed expectations for reg_status_table.
module tb_reg_status_table;
    logic Clock = 1'b0;
    logic Reset = 1'b1;
    int tests = 0;
    int fails = 0;

    reg_status_table_if #(.NUM_REGS(4), .DATA_W(16), .NUM_RS(4), .TAG_W(3), .RA_W(2)) bus ();

    reg_status_table #(.NUM_REGS(4), .DATA_W(16), .NUM_RS(4), .TAG_W(3), .RA_W(2)) dut (
        .Clock(Clock), .Reset(Reset), .bus(bus)
    );

    always #5 Clock = ~Clock;

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle();
        bus.flush = 0; bus.disp_valid = 0; bus.disp_rd = 0; bus.disp_tag = 0;
        bus.cdb_valid = 0; bus.cdb_tag = 0; bus.cdb_data = 0;
    endtask

    task automatic test_reset();
        logic [15:0] exp_data [4] = '{16'd2, 16'd4, 16'd3, 16'd5};
        idle();
        bus.rda_addr = 0; bus.rdb_addr = 0;
        step(); step();
        Reset = 0;
        step();
        for (int i = 0; i < 4; i++) begin
            bus.rda_addr = 2'(i);
            #1;
            tests++;
            if (bus.rda_data !== exp_data[i] || bus.rda_tag !== 3'd0) begin
                fails++;
                $display("FAIL reset_read R%0d: got tag %0d data %0d, want tag 0 data %0d", i, bus.rda_tag, bus.rda_data, exp_data[i]);
            end
        end
        tests++;
        if (bus.pending_cnt !== 3'd0 || bus.cdb_done !== 4'd0 || bus.disp_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_regs: cnt %0d done %b err %b, want 0 0000 0", bus.pending_cnt, bus.cdb_done, bus.disp_err);
        end
    endtask

    task automatic test_dispatch_cdb();
        bus.disp_valid = 1; bus.disp_rd = 1; bus.disp_tag = 2;
        step();
        idle();
        bus.rda_addr = 1;
        #1;
        tests++;
        if (bus.rda_tag !== 3'd2 || bus.pending_cnt !== 3'd1) begin
            fails++;
            $display("FAIL disp_r1: tag %0d cnt %0d, want 2 1", bus.rda_tag, bus.pending_cnt);
        end
        bus.cdb_valid = 1; bus.cdb_tag = 2; bus.cdb_data = 16'h00AA;
        #1;
        tests++;
        if (bus.rda_tag !== 3'd0 || bus.rda_data !== 16'h00AA) begin
            fails++;
            $display("FAIL bypass_r1: tag %0d data %h, want 0 00aa", bus.rda_tag, bus.rda_data);
        end
        step();
        idle();
        #1;
        tests++;
        if (bus.rda_tag !== 3'd0 || bus.rda_data !== 16'h00AA || bus.cdb_done !== 4'b0010 || bus.pending_cnt !== 3'd0) begin
            fails++;
            $display("FAIL cdb_r1: tag %0d data %h done %b cnt %0d, want 0 00aa 0010 0", bus.rda_tag, bus.rda_data, bus.cdb_done, bus.pending_cnt);
        end
        step();
        tests++;
        if (bus.cdb_done !== 4'b0000) begin
            fails++;
            $display("FAIL done_pulse: got %b, want 0000", bus.cdb_done);
        end
    endtask

    task automatic test_multi_match();
        bus.disp_valid = 1; bus.disp_rd = 0; bus.disp_tag = 1;
        step();
        bus.disp_rd = 3;
        step();
        idle();
        tests++;
        if (bus.pending_cnt !== 3'd2) begin
            fails++;
            $display("FAIL multi_cnt2: got %0d, want 2", bus.pending_cnt);
        end
        bus.cdb_valid = 1; bus.cdb_tag = 1; bus.cdb_data = 16'd7;
        step();
        idle();
        bus.rda_addr = 0; bus.rdb_addr = 3;
        #1;
        tests++;
        if (bus.rda_data !== 16'd7 || bus.rda_tag !== 3'd0 || bus.rdb_data !== 16'd7 || bus.rdb_tag !== 3'd0) begin
            fails++;
            $display("FAIL multi_write: R0 %0d/%0d R3 %0d/%0d, want 7/0 7/0", bus.rda_data, bus.rda_tag, bus.rdb_data, bus.rdb_tag);
        end
        tests++;
        if (bus.pending_cnt !== 3'd0 || bus.cdb_done !== 4'b0001) begin
            fails++;
            $display("FAIL multi_done: cnt %0d done %b, want 0 0001", bus.pending_cnt, bus.cdb_done);
        end
    endtask

    task automatic test_same_cycle();
        bus.disp_valid = 1; bus.disp_rd = 2; bus.disp_tag = 3;
        step();
        bus.disp_tag = 4;
        bus.cdb_valid = 1; bus.cdb_tag = 3; bus.cdb_data = 16'd9;
        bus.rda_addr = 2;
        #1;
        tests++;
        if (bus.rda_tag !== 3'd0 || bus.rda_data !== 16'd9) begin
            fails++;
            $display("FAIL same_read: tag %0d data %0d, want 0 9", bus.rda_tag, bus.rda_data);
        end
        step();
        idle();
        #1;
        tests++;
        if (bus.rda_tag !== 3'd4 || bus.rda_data !== 16'd9 || bus.pending_cnt !== 3'd1 || bus.cdb_done !== 4'b0100) begin
            fails++;
            $display("FAIL same_write: tag %0d data %0d cnt %0d done %b, want 4 9 1 0100", bus.rda_tag, bus.rda_data, bus.pending_cnt, bus.cdb_done);
        end
    endtask

    task automatic test_illegal();
        bus.disp_valid = 1; bus.disp_rd = 1; bus.disp_tag = 0;
        step();
        tests++;
        if (bus.disp_err !== 1'b1) begin
            fails++;
            $display("FAIL err_tag0: got %b, want 1", bus.disp_err);
        end
        bus.disp_tag = 5;
        step();
        idle();
        bus.rda_addr = 1;
        #1;
        tests++;
        if (bus.disp_err !== 1'b1 || bus.rda_tag !== 3'd0 || bus.pending_cnt !== 3'd1) begin
            fails++;
            $display("FAIL err_tag5: err %b R1 tag %0d cnt %0d, want 1 0 1", bus.disp_err, bus.rda_tag, bus.pending_cnt);
        end
        bus.cdb_valid = 1; bus.cdb_tag = 0; bus.cdb_data = 16'hDEAD;
        step();
        idle();
        tests++;
        if (bus.disp_err !== 1'b0 || bus.cdb_done !== 4'd0 || bus.rda_data !== 16'h00AA) begin
            fails++;
            $display("FAIL cdb_tag0: err %b done %b R1 %h, want 0 0000 00aa", bus.disp_err, bus.cdb_done, bus.rda_data);
        end
    endtask

    task automatic test_flush();
        bus.disp_valid = 1; bus.disp_rd = 0; bus.disp_tag = 1;
        step();
        bus.disp_rd = 1; bus.disp_tag = 2;
        step();
        idle();
        tests++;
        if (bus.pending_cnt !== 3'd3) begin
            fails++;
            $display("FAIL flush_pre: cnt %0d, want 3", bus.pending_cnt);
        end
        bus.flush = 1;
        bus.disp_valid = 1; bus.disp_rd = 3; bus.disp_tag = 3;
        bus.cdb_valid = 1; bus.cdb_tag = 2; bus.cdb_data = 16'h0055;
        step();
        idle();
        bus.rda_addr = 1; bus.rdb_addr = 3;
        #1;
        tests++;
        if (bus.pending_cnt !== 3'd0 || bus.disp_err !== 1'b0 || bus.cdb_done !== 4'b0010) begin
            fails++;
            $display("FAIL flush_regs: cnt %0d err %b done %b, want 0 0 0010", bus.pending_cnt, bus.disp_err, bus.cdb_done);
        end
        tests++;
        if (bus.rda_tag !== 3'd0 || bus.rda_data !== 16'h0055 || bus.rdb_tag !== 3'd0 || bus.rdb_data !== 16'd7) begin
            fails++;
            $display("FAIL flush_table: R1 %h/%0d R3 %0d/%0d, want 0055/0 7/0", bus.rda_data, bus.rda_tag, bus.rdb_data, bus.rdb_tag);
        end
        bus.rda_addr = 0; bus.rdb_addr = 2;
        #1;
        tests++;
        if (bus.rda_tag !== 3'd0 || bus.rda_data !== 16'd7 || bus.rdb_tag !== 3'd0 || bus.rdb_data !== 16'd9) begin
            fails++;
            $display("FAIL flush_r0r2: R0 %0d/%0d R2 %0d/%0d, want 7/0 9/0", bus.rda_data, bus.rda_tag, bus.rdb_data, bus.rdb_tag);
        end
    endtask

    task automatic test_reset_mid();
        bus.disp_valid = 1; bus.disp_rd = 0; bus.disp_tag = 1;
        step();
        idle();
        bus.cdb_valid = 1; bus.cdb_tag = 1; bus.cdb_data = 16'h1234;
        #2;
        Reset = 1;
        #1;
        bus.rda_addr = 0; bus.rdb_addr = 3;
        #1;
        tests++;
        if (bus.rda_tag !== 3'd0 || bus.rda_data !== 16'd2 || bus.rdb_data !== 16'd5 || bus.pending_cnt !== 3'd0) begin
            fails++;
            $display("FAIL reset_mid: R0 %0d/%0d R3 %0d cnt %0d, want 2/0 5 0", bus.rda_data, bus.rda_tag, bus.rdb_data, bus.pending_cnt);
        end
        step();
        idle();
        tests++;
        if (bus.cdb_done !== 4'd0 || bus.rda_data !== 16'd2) begin
            fails++;
            $display("FAIL reset_hold: done %b R0 %0d, want 0000 2", bus.cdb_done, bus.rda_data);
        end
        Reset = 0;
        step();
        tests++;
        if (bus.rda_data !== 16'd2 || bus.pending_cnt !== 3'd0 || bus.cdb_done !== 4'd0) begin
            fails++;
            $display("FAIL reset_release: R0 %0d cnt %0d done %b, want 2 0 0000", bus.rda_data, bus.pending_cnt, bus.cdb_done);
        end
    endtask

    initial begin
        test_reset();
        test_dispatch_cdb();
        test_multi_match();
        test_same_cycle();
        test_illegal();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
